// File: rtl/lock_pkg.sv
// Shared types for the two-button code lock: FSM states and decoded button symbols.
package lock_pkg;

    // One-hot: each state is the longest matched prefix of the code 0,1,0,1,1.
    typedef enum logic [5:0] {
        S_IDLE = 6'b000001,
        S_0    = 6'b000010,
        S_01   = 6'b000100,
        S_010  = 6'b001000,
        S_0101 = 6'b010000,
        S_OPEN = 6'b100000
    } lock_state_t;

    typedef enum logic [1:0] {
        SYM_NONE = 2'b00,
        SYM_0    = 2'b01,
        SYM_1    = 2'b10,
        SYM_BAD  = 2'b11
    } sym_t;

endpackage

// File: rtl/lock_sym_decode.sv
// Combinational decode of the two debounced buttons into one symbol per clock.
module lock_sym_decode
    import lock_pkg::*;
(
    input  logic b0,
    input  logic b1,
    output sym_t sym
);

    always_comb begin
        sym = SYM_NONE;
        case ({b1, b0})
            2'b01:   sym = SYM_0;
            2'b10:   sym = SYM_1;
            2'b11:   sym = SYM_BAD;
            default: sym = SYM_NONE;
        endcase
    end

endmodule

// File: rtl/detect_01011.sv
// Moore detector for the overlapping code 0,1,0,1,1; unlock is a one-cycle pulse
// driven straight from a flop so the door actuator never sees a decode glitch.
module detect_01011
    import lock_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic b0,
    input  logic b1,
    output logic unlock
);

    sym_t        sym;
    lock_state_t state, state_nxt;
    logic        unlock_q;

    lock_sym_decode u_dec (
        .b0  (b0),
        .b1  (b1),
        .sym (sym)
    );

    // unlock_q tracks (state == S_OPEN) exactly, since it is loaded from the same next-state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            unlock_q <= 1'b0;
        end else begin
            state    <= state_nxt;
            unlock_q <= (state_nxt == S_OPEN);
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (sym == SYM_0) state_nxt = S_0;
            end
            S_0: begin
                if (sym == SYM_1) state_nxt = S_01;
            end
            S_01: begin
                if (sym == SYM_0)      state_nxt = S_010;
                else if (sym == SYM_1) state_nxt = S_IDLE;
            end
            S_010: begin
                if (sym == SYM_0)      state_nxt = S_0;
                else if (sym == SYM_1) state_nxt = S_0101;
            end
            S_0101: begin
                if (sym == SYM_0)      state_nxt = S_010;
                else if (sym == SYM_1) state_nxt = S_OPEN;
            end
            // The code has no self-overlap, so leaving OPEN looks like leaving IDLE.
            S_OPEN: begin
                state_nxt = (sym == SYM_0) ? S_0 : S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
        if (sym == SYM_BAD) state_nxt = S_IDLE;
    end

    assign unlock = unlock_q;

endmodule

// File: tb/tb_detect_01011.sv
// Bench for detect_01011: directed scenarios plus a random stream checked against a
// symbol-history model (unlock follows any edge whose last five symbols spell 01011).
module tb_detect_01011;
    import lock_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic b0 = 1'b0;
    logic b1 = 1'b0;
    logic unlock;

    int   total = 0;
    int   bad = 0;
    bit   hist[$];
    logic exp_unlock = 1'b0;

    detect_01011 dut (
        .clk    (clk),
        .reset  (reset),
        .b0     (b0),
        .b1     (b1),
        .unlock (unlock)
    );

    always #5 clk = ~clk;

    // Apply one button pair for one edge, then sample 1 time unit after it.
    task automatic step(input logic x0, input logic x1);
        int n;
        b0 = x0;
        b1 = x1;
        @(posedge clk);
        #1;
        if (x0 && x1) hist.delete();
        else if (x0 ^ x1) hist.push_back(x1);
        if (hist.size() > 8) void'(hist.pop_front());
        n = hist.size();
        exp_unlock = (x0 ^ x1) && n >= 5 && hist[n-5] == 0 && hist[n-4] == 1 &&
                     hist[n-3] == 0 && hist[n-2] == 1 && hist[n-1] == 1;
    endtask

    // '0'/'1' symbols, 'x' both pressed, '-' idle; bit i of obs = unlock after symbol i.
    task automatic play(input string s, input bit clr, output int obs);
        obs = 0;
        if (clr) step(1'b1, 1'b1);
        for (int i = 0; i < s.len(); i++) begin
            case (s[i])
                "0":     step(1'b1, 1'b0);
                "1":     step(1'b0, 1'b1);
                "x":     step(1'b1, 1'b1);
                default: step(1'b0, 1'b0);
            endcase
            if (unlock === 1'b1) obs |= (1 << i);
        end
    endtask

    task automatic test_reset();
        #1;
        total++;
        if (unlock !== 1'b0) begin bad++; $display("FAIL reset_t0: unlock=%b want 0", unlock); end
        for (int i = 0; i < 4; i++) begin
            b0 = 1'($urandom);
            b1 = 1'($urandom);
            @(posedge clk);
            #1;
            total++;
            if (unlock !== 1'b0) begin bad++; $display("FAIL reset_hold: unlock=%b want 0", unlock); end
        end
        b0 = 1'b0;
        b1 = 1'b0;
        hist.delete();
        #2 reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0);
            total++;
            if (unlock !== 1'b0) begin bad++; $display("FAIL reset_idle: unlock=%b want 0", unlock); end
        end
    endtask

    task automatic test_single();
        int o;
        play("01011--", 1'b1, o);
        total++;
        if (o !== 32'h10) begin bad++; $display("FAIL single: pulse mask=%h want %h", o, 32'h10); end
    endtask

    task automatic test_overlap();
        int o;
        play("01011101011-", 1'b1, o);
        total++;
        if (o !== 32'h410) begin bad++; $display("FAIL overlap: pulse mask=%h want %h", o, 32'h410); end
    endtask

    task automatic test_gaps();
        int o;
        play("01--011-", 1'b1, o);
        total++;
        if (o !== 32'h40) begin bad++; $display("FAIL gap_idle: pulse mask=%h want %h", o, 32'h40); end
        play("011011-", 1'b1, o);
        total++;
        if (o !== 32'h0) begin bad++; $display("FAIL near_miss: pulse mask=%h want 0", o); end
        play("01001011-", 1'b1, o);
        total++;
        if (o !== 32'h80) begin bad++; $display("FAIL restart: pulse mask=%h want %h", o, 32'h80); end
    endtask

    task automatic test_invalid();
        int o;
        play("0101x", 1'b1, o);
        total++;
        if (dut.state !== S_IDLE) begin bad++; $display("FAIL invalid_state: state=%b want %b", dut.state, S_IDLE); end
        play("1-", 1'b0, o);
        total++;
        if (o !== 32'h0) begin bad++; $display("FAIL invalid_abort: pulse mask=%h want 0", o); end
        play("01011-", 1'b0, o);
        total++;
        if (o !== 32'h10) begin bad++; $display("FAIL invalid_recover: pulse mask=%h want %h", o, 32'h10); end
    endtask

    task automatic test_async_reset();
        int o;
        play("0101", 1'b1, o);
        b0 = 1'b0;
        b1 = 1'b0;
        #2 reset = 1'b0;
        #2;
        total++;
        if (dut.state !== S_IDLE) begin bad++; $display("FAIL async_state: state=%b want %b", dut.state, S_IDLE); end
        total++;
        if (unlock !== 1'b0) begin bad++; $display("FAIL async_unlock: unlock=%b want 0", unlock); end
        #2 reset = 1'b1;
        hist.delete();
        play("1-", 1'b0, o);
        total++;
        if (o !== 32'h0) begin bad++; $display("FAIL async_abort: pulse mask=%h want 0", o); end
    endtask

    task automatic test_random();
        int r;
        int pulses = 0;
        int errs = 0;
        for (int i = 0; i < 600; i++) begin
            r = $urandom_range(0, 99);
            if (r < 45)      step(1'b1, 1'b0);
            else if (r < 90) step(1'b0, 1'b1);
            else if (r < 96) step(1'b0, 1'b0);
            else             step(1'b1, 1'b1);
            if (exp_unlock) pulses++;
            total++;
            if (unlock !== exp_unlock) begin
                bad++;
                errs++;
                if (errs <= 10) $display("FAIL random[%0d]: unlock=%b want %b", i, unlock, exp_unlock);
            end
        end
        $display("random stream: %0d expected pulses", pulses);
    endtask

    initial begin
        test_reset();
        test_single();
        test_overlap();
        test_gaps();
        test_invalid();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
